// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_pkg
// Purpose : Shared state encoding and constants for the clock-divider controller.
// Rev     : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    localparam int DEFAULT_DIV_RATIO_WD = 8;
    localparam int MIN_VALID_RATIO      = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GATE = 3'd1,
        LOAD = 3'd2,
        HOLD = 3'd3,
        ACK  = 3'd4
    } state_e;

    function automatic int settle_cnt_wd(input int settle_cyc);
        return $clog2(settle_cyc + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ctrl_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_rr_arb
// Purpose : Combinational round-robin arbiter; lowest requester >= rr_ptr wins, wrapping.
// Rev     : 1.0  initial release
// ============================================================================
module clk_div_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner
);

    // Two descending passes: the first finds the lowest set bit overall (the
    // wrap-around candidate), the second overrides it with the lowest at/above rr_ptr.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) >= rr_ptr)) begin
                winner = IDX_W'(i);
            end
        end
        grant = '0;
        if (|req) begin
            grant[winner] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_ctrl
// Purpose : Glitch-safe ratio-change controller for the integer clock divider.
//           Optional ratio check enabled by macro CLK_DIV_CTRL_RATIO_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_RATIO_WD  = DEFAULT_DIV_RATIO_WD,
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_CYC    = 4,
    parameter int DEFAULT_RATIO = 2
) (
    input  logic                            clk_ref,
    input  logic                            rst,
    input  logic                            en_in,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DIV_RATIO_WD-1:0] req_ratio,
    output logic [NUM_REQ-1:0]              ack,
    output logic [NUM_REQ-1:0]              nack,
    output logic                            busy,
    output logic                            div_en_out,
    output logic [DIV_RATIO_WD-1:0]         div_ratio_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = settle_cnt_wd(SETTLE_CYC);
    localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [DIV_RATIO_WD-1:0] RESET_RATIO = DIV_RATIO_WD'(DEFAULT_RATIO);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]          win_q, win_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic [DIV_RATIO_WD-1:0]   ratio_q, ratio_d;
    logic [DIV_RATIO_WD-1:0]   div_ratio_q, div_ratio_d;
    logic                      div_en_q, div_en_d;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
    logic                      nack_q, nack_d;
`endif

    logic [NUM_REQ-1:0]        arb_grant;
    logic [IDX_W-1:0]          arb_winner;
    logic [DIV_RATIO_WD-1:0]   arb_ratio;

    clk_div_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    assign arb_ratio = req_ratio[int'(arb_winner)*DIV_RATIO_WD +: DIV_RATIO_WD];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        grant_d     = grant_q;
        ratio_d     = ratio_q;
        div_ratio_d = div_ratio_q;
        div_en_d    = div_en_q;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
        nack_d      = nack_q;
`endif
        case (state_q)
            IDLE: begin
                div_en_d = en_in;
                if (|req) begin
                    win_d   = arb_winner;
                    grant_d = arb_grant;
                    ratio_d = arb_ratio;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
                    nack_d  = 1'b0;
                    if (arb_ratio < DIV_RATIO_WD'(MIN_VALID_RATIO)) begin
                        nack_d  = 1'b1;
                        state_d = ACK;
                    end else
`endif
                    if (arb_ratio == div_ratio_q) begin
                        state_d = ACK;
                    end else begin
                        div_en_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = GATE;
                    end
                end
            end
            GATE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                div_ratio_d = ratio_q;
                cnt_d       = '0;
                state_d     = HOLD;
            end
            HOLD: begin
                if (cnt_q == SETTLE_LAST) begin
                    div_en_d = en_in;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                rr_ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            grant_q     <= '0;
            ratio_q     <= RESET_RATIO;
            div_ratio_q <= RESET_RATIO;
            div_en_q    <= 1'b0;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
            nack_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            grant_q     <= grant_d;
            ratio_q     <= ratio_d;
            div_ratio_q <= div_ratio_d;
            div_en_q    <= div_en_d;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
            nack_q      <= nack_d;
`endif
        end
    end

`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
    assign ack  = (state_q == ACK && !nack_q) ? grant_q : '0;
    assign nack = (state_q == ACK &&  nack_q) ? grant_q : '0;
`else
    assign ack  = (state_q == ACK) ? grant_q : '0;
    assign nack = '0;
`endif

    assign busy          = (state_q != IDLE);
    assign div_en_out    = div_en_q;
    assign div_ratio_out = div_ratio_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_div_ctrl
// Purpose : Scoreboard bench for clk_div_ctrl with a transaction-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int N   = 3;
    localparam int W   = 8;
    localparam int S   = 4;
    localparam int DEF = 2;

    logic             clk_ref = 1'b0;
    logic             rst     = 1'b1;
    logic             en_in   = 1'b1;
    logic [N-1:0]     req     = '0;
    logic [N*W-1:0]   req_ratio = '0;
    logic [N-1:0]     ack;
    logic [N-1:0]     nack;
    logic             busy;
    logic             div_en_out;
    logic [W-1:0]     div_ratio_out;

    clk_div_ctrl #(
        .DIV_RATIO_WD  (W),
        .NUM_REQ       (N),
        .SETTLE_CYC    (S),
        .DEFAULT_RATIO (DEF)
    ) dut (
        .clk_ref       (clk_ref),
        .rst           (rst),
        .en_in         (en_in),
        .req           (req),
        .req_ratio     (req_ratio),
        .ack           (ack),
        .nack          (nack),
        .busy          (busy),
        .div_en_out    (div_en_out),
        .div_ratio_out (div_ratio_out)
    );

    always #5 clk_ref = ~clk_ref;

    int cyc = 0;
    always @(posedge clk_ref) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int ratio;
        int ack_cyc;
        int low;
        bit chg;
        int chg_cyc;
        bit is_nack;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Reference model state: current ratio and round-robin pointer.
    int   m_cur = DEF;
    int   m_rr  = 0;
    int   rat[N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ack/nack pulse and checks invariants.
    initial begin
        int            low_cnt;
        int            last_chg;
        logic [W-1:0]  prev_ratio;
        bit            chk_busy;
        exp_t          e;
        logic [N-1:0]  ev;
        low_cnt = 0; last_chg = -1; prev_ratio = '0; chk_busy = 1'b0;
        forever begin
            @(negedge clk_ref);
            if (!mon_en) begin
                low_cnt    = 0;
                chk_busy   = 1'b0;
                prev_ratio = div_ratio_out;
            end else begin
                if (chk_busy) begin
                    chk("busy_after_ack", busy, 0);
                    chk_busy = 1'b0;
                end
                if (div_ratio_out !== prev_ratio) begin
                    last_chg = cyc;
                    chk("ratio_change_while_enabled", div_en_out, 0);
                    prev_ratio = div_ratio_out;
                end
                if (div_en_out === 1'b0) low_cnt++;
                if (ack != '0 || nack != '0) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ack", {ack, nack}, 0);
                    end else begin
                        e  = sb_q.pop_front();
                        ev = '0;
                        ev[e.idx] = 1'b1;
                        chk("ack_vec",  ack,  e.is_nack ? '0 : ev);
                        chk("nack_vec", nack, e.is_nack ? ev : '0);
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("ratio_at_ack", div_ratio_out, e.ratio);
                        chk("en_low_cycles", low_cnt, e.low);
                        if (e.chg) chk("ratio_visible_cycle", last_chg, e.chg_cyc);
                    end
                    low_cnt  = 0;
                    chk_busy = 1'b1;
                end
            end
        end
    end

    // Issue requests on 'mask' simultaneously and predict every grant from the rules.
    task automatic run_batch(input logic [N-1:0] mask);
        logic [N-1:0] pending;
        int           t, w, budget, lat;
        bit           nk;
        exp_t         e;
        @(posedge clk_ref);
        #1;
        for (int i = 0; i < N; i++) req_ratio[i*W +: W] = W'(rat[i]);
        req     = mask;
        t       = cyc;
        pending = mask;
        while (pending != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pending[(m_rr + k) % N]) w = (m_rr + k) % N;
            end
            nk = 1'b0;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
            nk = (rat[w] < 2);
`endif
            e.idx = w; e.is_nack = nk; e.chg = 1'b0; e.chg_cyc = 0;
            if (nk || rat[w] == m_cur) begin
                lat = 1; e.low = 0;
            end else begin
                lat = 2*S + 2; e.low = 2*S + 1;
                e.chg = 1'b1; e.chg_cyc = t + S + 2;
                m_cur = rat[w];
            end
            e.ratio   = m_cur;
            e.ack_cyc = t + lat;
            sb_q.push_back(e);
            m_rr       = (w + 1) % N;
            pending[w] = 1'b0;
            t          = e.ack_cyc + 1;
        end
        budget = 200;
        while (req != '0 && budget > 0) begin
            @(negedge clk_ref);
            req = req & ~(ack | nack);
            budget--;
        end
        if (req != '0) begin
            chk("batch_timeout_req_left", req, 0);
            req = '0;
        end
        @(negedge clk_ref);
        chk("sb_drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, t, r;
        logic [N-1:0] m;

        // Reset behaviour and enable tracking after release.
        repeat (3) @(posedge clk_ref);
        @(negedge clk_ref);
        chk("rst_ratio", div_ratio_out, DEF);
        chk("rst_en", div_en_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_nack", nack, 0);
        rst = 1'b0;
        @(negedge clk_ref);
        chk("en_after_release", div_en_out, 1);
        chk("idle_ratio", div_ratio_out, DEF);
        chk("idle_busy", busy, 0);
        mon_en = 1'b1;

        // Directed: full change, same-ratio shortcut, simultaneous pair twice.
        rat[0] = 6; rat[1] = 0; rat[2] = 0;
        run_batch(3'b001);
        rat[1] = 6;
        run_batch(3'b010);
        rat[0] = 4; rat[1] = 8;
        run_batch(3'b011);
        chk("pair_final_ratio", div_ratio_out, 8);
        run_batch(3'b011);
        rat[0] = 1;
        run_batch(3'b001);

        // Randomised batches, including wrap-around and same-ratio picks.
        for (int b = 0; b < 24; b++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                rat[i] = ($urandom_range(0, 3) == 0) ? m_cur : int'($urandom_range(0, 255));
            end
            run_batch(m);
            repeat ($urandom_range(0, 3)) @(posedge clk_ref);
        end

        // Reset mid-sequence: abort, reset values, no ack afterwards.
        mon_en = 1'b0;
        @(negedge clk_ref);
        r = (m_cur == 6) ? 7 : 6;
        @(posedge clk_ref);
        #1;
        req_ratio[0 +: W] = W'(r);
        req = 3'b001;
        t   = cyc;
        while (cyc < t + 5) begin
            @(posedge clk_ref);
            #1;
        end
        rst = 1'b1;
        @(posedge clk_ref);
        #1;
        rst = 1'b0;
        req = '0;
        @(negedge clk_ref);
        chk("abort_ratio", div_ratio_out, DEF);
        chk("abort_en", div_en_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack", ack, 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk_ref);
            if (ack != '0) seen++;
        end
        chk("no_ack_after_abort", seen, 0);
        m_cur = DEF;
        m_rr  = 0;
        mon_en = 1'b1;

        // Pointer was reset: requester 0 must win again.
        rat[0] = 3; rat[1] = 5; rat[2] = 9;
        run_batch(3'b011);
        chk("post_abort_ratio", div_ratio_out, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
